// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared types and constants for the fetch sequencing controller.
package fetch_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h3000;

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating wait counter; 'expired' flags the cycle that completes the LIMIT-th wait.
module fetch_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Asserted while the running count is about to reach (or already holds) LIMIT.
  assign expired = run && !clr && (cnt_q >= CW'(LIMIT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues imem reads, presents words to decode,
// and squashes in-flight reads on redirect.
module fetch_seq_ctrl
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned       TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_npc,
  output logic              busy,
  output logic              timeout_err,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [ADDR_W-1:0] inpc_q, inpc_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              waiting;
  logic              hs;
  logic              timer_run;
  logic              timer_clr;
  logic              timer_expired;

  // Decode handshake: a word transfers on any cycle with inst_valid & inst_ready;
  // inst_valid never drops and inst_* never change until that happens (or a redirect).
  assign hs        = valid_q & inst_ready;
  assign waiting   = (state_q == WAIT) || (state_q == FLUSH);
  assign timer_run = waiting && !imem_ack;
  assign timer_clr = !timer_run;

  fetch_wait_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .run    (timer_run),
    .clr    (timer_clr),
    .expired(timer_expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    data_d  = data_q;
    ipc_d   = ipc_q;
    inpc_d  = inpc_q;
    err_d   = err_q | timer_expired;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (fetch_en) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_ack) begin
            state_d = IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = FLUSH;
          end
        end else if (imem_ack) begin
          state_d = HOLD;
          req_d   = 1'b0;
          valid_d = 1'b1;
          data_d  = imem_rdata;
          ipc_d   = pc_q;
          inpc_d  = pc_q + ADDR_W'(1);
          pc_d    = pc_q + ADDR_W'(1);
        end
      end
      HOLD: begin
        // A redirect coinciding with the handshake still lets that word go.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (hs) begin
          valid_d = 1'b0;
          if (fetch_en) begin
            state_d = WAIT;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
      inpc_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
      inpc_q  <= inpc_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst_valid  = valid_q;
  assign inst_data   = data_q;
  assign inst_pc     = ipc_q;
  assign inst_npc    = inpc_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: directed scenarios plus a transaction-level model checked every cycle.
module tb_fetch_seq_ctrl;
  import fetch_seq_ctrl_pkg::*;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic [15:0] inst_npc;
  logic        busy;
  logic        timeout_err;
  state_e      dbg_state;

  fetch_seq_ctrl #(
    .ADDR_W(16), .DATA_W(16), .RESET_PC(16'h3000), .TIMEOUT_CYC(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_npc(inst_npc),
    .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur within the cycle budget", name);
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // ---------------- memory model ----------------
  int mem_lat   = 0;
  int mem_wcnt  = 0;
  bit dead_mode = 0;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clock);
      #2;
      if (!reset_n) begin
        imem_ack = 1'b0;
        mem_wcnt = 0;
      end else if (imem_ack) begin
        imem_ack = 1'b0;
        mem_wcnt = 0;
      end else if (imem_req) begin
        if (mem_wcnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = dead_mode ? 16'hDEAD : mem_word(imem_addr);
        end else begin
          mem_wcnt++;
        end
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  logic [31:0] exp_q[$];
  logic [15:0] model_pc;
  bit          squash;
  int          model_wcnt;
  bit          model_err;
  int          n_accepted = 0;
  logic        prev_req, prev_ack, prev_valid, prev_ready, prev_redirect;
  logic [15:0] prev_addr, prev_ipc, prev_idata;

  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      model_pc   = 16'h3000;
      squash     = 0;
      model_wcnt = 0;
      model_err  = 0;
      prev_req   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      check("busy", busy, imem_req || inst_valid);
      check("timeout_err", timeout_err, model_err);
      if (prev_req && !prev_ack) begin
        check("req_held", imem_req, 1'b1);
        check("addr_stable", imem_addr, prev_addr);
      end
      if (imem_req && !prev_req) check("req_addr", imem_addr, model_pc);
      if (prev_valid && !prev_ready && !prev_redirect) begin
        check("hold_valid", inst_valid, 1'b1);
        check("hold_pc", inst_pc, prev_ipc);
        check("hold_data", inst_data, prev_idata);
      end
      if (inst_valid && inst_ready) begin
        check("inst_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          logic [31:0] e;
          logic [15:0] e_npc;
          e = exp_q.pop_front();
          e_npc = e[31:16] + 16'd1;
          check("sb_pc", inst_pc, e[31:16]);
          check("sb_npc", inst_npc, e_npc);
          check("sb_data", inst_data, e[15:0]);
        end
        n_accepted++;
      end
      // What the next edge must do, from the transaction rules
      if (imem_req && redirect_valid) squash = 1;
      if (imem_req && imem_ack) begin
        if (!squash) begin
          exp_q.push_back({imem_addr, imem_rdata});
          model_pc = imem_addr + 16'd1;
        end
        squash = 0;
      end
      if (redirect_valid) begin
        model_pc = redirect_pc;
        if (inst_valid && !inst_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (imem_req && !imem_ack) begin
        model_wcnt++;
        if (model_wcnt >= TO) model_err = 1;
      end else begin
        model_wcnt = 0;
      end
      prev_req      = imem_req;
      prev_ack      = imem_ack;
      prev_addr     = imem_addr;
      prev_valid    = inst_valid;
      prev_ready    = inst_ready;
      prev_redirect = redirect_valid;
      prev_ipc      = inst_pc;
      prev_idata    = inst_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req_rise(input string name);
    logic last;
    last = imem_req;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (imem_req && !last) return;
      last = imem_req;
    end
    bound_fail(name);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (inst_valid) return;
    end
    bound_fail(name);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!busy) return;
    end
    bound_fail(name);
  endtask

  // ---------------- directed scenarios ----------------
  logic [15:0] t1_addr [3] = '{16'h3000, 16'h3001, 16'h3002};
  logic [15:0] t1_npc  [3] = '{16'h3001, 16'h3002, 16'h3003};
  logic [15:0] t1_data [3] = '{16'h6A5A, 16'h6A5B, 16'h6A58};

  initial begin
    int acc;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;

    #12;
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 16'h3000);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_data", inst_data, 16'h0000);
    check("rst_pc", inst_pc, 16'h0000);
    check("rst_npc", inst_npc, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_err", timeout_err, 1'b0);
    check("rst_state", dbg_state, IDLE);
    reset_n = 1'b1;
    tick();

    // Sequential fetch, memory acks one cycle after the request
    mem_lat  = 1;
    fetch_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_req_rise("t1_req");
      check("t1_addr", imem_addr, t1_addr[k]);
      wait_valid("t1_valid");
      check("t1_pc", inst_pc, t1_addr[k]);
      check("t1_npc", inst_npc, t1_npc[k]);
      check("t1_data", inst_data, t1_data[k]);
    end

    // Decode stalls for five cycles
    wait_req_rise("t2_req");
    inst_ready = 1'b0;
    wait_valid("t2_valid");
    for (int i = 0; i < 5; i++) begin
      check("t2_valid_held", inst_valid, 1'b1);
      check("t2_pc_held", inst_pc, 16'h3003);
      check("t2_data_held", inst_data, 16'h6A59);
      check("t2_no_req", imem_req, 1'b0);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    check("t2_valid_drop", inst_valid, 1'b0);
    check("t2_req_after", imem_req, 1'b1);
    check("t2_addr_after", imem_addr, 16'h3004);
    fetch_en = 1'b0;
    wait_idle("t2_idle");

    // Redirect while the read is in flight; 0xDEAD must be discarded
    mem_lat   = 3;
    dead_mode = 1;
    fetch_en  = 1'b1;
    wait_req_rise("t3_req");
    check("t3_addr", imem_addr, 16'h3005);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h4000;
    tick();
    redirect_valid = 1'b0;
    check("t3_flush_state", dbg_state, FLUSH);
    check("t3_flush_req", imem_req, 1'b1);
    check("t3_flush_valid", inst_valid, 1'b0);
    wait_req_rise("t3_req2");
    dead_mode = 0;
    check("t3_new_addr", imem_addr, 16'h4000);
    wait_valid("t3_valid");
    check("t3_pc", inst_pc, 16'h4000);
    check("t3_data", inst_data, 16'h1A5A);

    // PC wrap at 0xFFFF
    fetch_en = 1'b0;
    mem_lat  = 0;
    wait_idle("t4_idle");
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    wait_req_rise("t4_req");
    check("t4_addr", imem_addr, 16'hFFFF);
    wait_valid("t4_valid");
    check("t4_pc", inst_pc, 16'hFFFF);
    check("t4_npc", inst_npc, 16'h0000);
    check("t4_data", inst_data, 16'hA5A5);

    // Redirect on the same cycle as the decode handshake
    wait_req_rise("t5_req");
    check("t5_wrap_addr", imem_addr, 16'h0000);
    wait_valid("t5_valid");
    redirect_valid = 1'b1;
    redirect_pc    = 16'h5000;
    acc            = n_accepted;
    tick();
    redirect_valid = 1'b0;
    check("t5_valid_drop", inst_valid, 1'b0);
    check("t5_accepted_once", n_accepted, acc + 1);
    wait_req_rise("t5_req2");
    check("t5_target_addr", imem_addr, 16'h5000);

    // Memory never acks; sticky timeout, then async reset
    fetch_en = 1'b0;
    wait_idle("t6_idle");
    mem_lat  = 1000;
    fetch_en = 1'b1;
    wait_req_rise("t6_req");
    repeat (7) tick();
    check("t6_err_before", timeout_err, 1'b0);
    tick();
    check("t6_err_set", timeout_err, 1'b1);
    repeat (3) tick();
    check("t6_err_sticky", timeout_err, 1'b1);
    check("t6_still_req", imem_req, 1'b1);
    check("t6_addr", imem_addr, 16'h5001);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_arst_req", imem_req, 1'b0);
    check("t6_arst_err", timeout_err, 1'b0);
    check("t6_arst_busy", busy, 1'b0);
    check("t6_arst_valid", inst_valid, 1'b0);
    check("t6_arst_addr", imem_addr, 16'h3000);
    fetch_en = 1'b0;
    #20;
    reset_n = 1'b1;
    tick();
    tick();
    check("t6_post_idle", imem_req, 1'b0);
    check("t6_sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
